// File: rtl/alu_mdu_unit.sv
// Registered ALU plus iterative unsigned multiply/divide for the multi-cycle RISC-V datapath.
// Base integer ops finish in one cycle; MUL/MULHU/DIVU/REMU take WIDTH cycles behind busy/done.
module alu_mdu_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       ALUOp,
  input  logic [2:0]       func3,
  input  logic [1:0]       func7,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy,
  output logic             done,
  output logic             illegal
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;
  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_XOR, OP_OR, OP_AND, OP_SLT, OP_SLTU,
    OP_MUL, OP_MULHU, OP_DIVU, OP_REMU, OP_ILL
  } op_e;

  state_e             state_q, state_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               hi_q, hi_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               zero_q, zero_d, busy_q, busy_d, done_q, done_d, ill_q, ill_d;

  op_e                op;
  logic [WIDTH-1:0]   alu_res;
  logic [WIDTH:0]     mul_sum, div_sh, div_diff;
  logic [2*WIDTH-1:0] mul_next, div_next;
  logic               start_ok;

  always_comb begin
    op = OP_ILL;
    case (ALUOp)
      2'b00: op = OP_ADD;
      2'b01: op = OP_SUB;
      2'b11: begin
        case (func3)
          3'b000: op = OP_ADD;
          3'b100: op = OP_XOR;
          3'b110: op = OP_OR;
          3'b111: op = OP_AND;
          3'b010: op = OP_SLT;
          3'b011: op = OP_SLTU;
          default: op = OP_ILL;
        endcase
      end
      default: begin
        if (!func7[0]) begin
          case (func3)
            3'b000: op = func7[1] ? OP_SUB : OP_ADD;
            3'b100: op = OP_XOR;
            3'b110: op = OP_OR;
            3'b111: op = OP_AND;
            3'b010: op = OP_SLT;
            3'b011: op = OP_SLTU;
            default: op = OP_ILL;
          endcase
        end else begin
          case (func3)
            3'b000: op = OP_MUL;
            3'b011: op = OP_MULHU;
            3'b101: op = OP_DIVU;
            3'b111: op = OP_REMU;
            default: op = OP_ILL;
          endcase
        end
      end
    endcase
  end

  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD:  alu_res = a + b;
      OP_SUB:  alu_res = a - b;
      OP_XOR:  alu_res = a ^ b;
      OP_OR:   alu_res = a | b;
      OP_AND:  alu_res = a & b;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, a < b};
      default: alu_res = '0;
    endcase
  end

  // acc holds {partial product, remaining multiplier} for MUL and
  // {partial remainder, dividend/quotient bits} for DIV.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};
    div_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff = div_sh - {1'b0, opnd_q};
    // A zero divisor never borrows, so quotient fills with ones and the remainder becomes a.
    div_next = div_diff[WIDTH] ? {div_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                               : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    hi_d     = hi_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    ill_d    = ill_q;
    start_ok = start && (state_q == S_IDLE || state_q == S_DONE);
    case (state_q)
      S_MUL: begin
        acc_d = mul_next;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d  = S_DONE;
          result_d = hi_q ? mul_next[2*WIDTH-1:WIDTH] : mul_next[WIDTH-1:0];
        end
      end
      S_DIV: begin
        acc_d = div_next;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d  = S_DONE;
          result_d = hi_q ? div_next[2*WIDTH-1:WIDTH] : div_next[WIDTH-1:0];
        end
      end
      default: begin
        state_d = S_IDLE;
        if (start_ok) begin
          ill_d = (op == OP_ILL);
          cnt_d = '0;
          case (op)
            OP_MUL, OP_MULHU: begin
              state_d = S_MUL;
              acc_d   = {{WIDTH{1'b0}}, b};
              opnd_d  = a;
              hi_d    = (op == OP_MULHU);
            end
            OP_DIVU, OP_REMU: begin
              state_d = S_DIV;
              acc_d   = {{WIDTH{1'b0}}, a};
              opnd_d  = b;
              hi_d    = (op == OP_REMU);
            end
            default: begin
              state_d  = S_DONE;
              result_d = alu_res;
            end
          endcase
        end
      end
    endcase
    zero_d = (result_d == '0);
    busy_d = (state_d == S_MUL) || (state_d == S_DIV);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      opnd_q   <= '0;
      hi_q     <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ill_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      hi_q     <= hi_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      ill_q    <= ill_d;
    end
  end

  assign result  = result_q;
  assign zero    = zero_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign illegal = ill_q;
endmodule

// File: tb/tb_alu_mdu_unit.sv
// Self-checking bench for alu_mdu_unit: directed vector table, multi-cycle corner sequences,
// and random operations checked against an arithmetic reference model.
module tb_alu_mdu_unit;
  logic        clk, rst, start;
  logic [1:0]  ALUOp, func7;
  logic [2:0]  func3;
  logic [31:0] a, b, result;
  logic        zero, busy, done, illegal;

  int total = 0, passed = 0, ovl = 0;

  alu_mdu_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .ALUOp(ALUOp), .func3(func3), .func7(func7),
    .a(a), .b(b), .result(result), .zero(zero), .busy(busy), .done(done), .illegal(illegal)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [1:0]  op;
    logic [2:0]  f3;
    logic [1:0]  f7;
    logic [31:0] x, y, r;
    bit          ill, it;
  } vec_t;
  vec_t vt[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic vec_t mk(string nm, logic [1:0] op, logic [2:0] f3, logic [1:0] f7,
                              logic [31:0] x, logic [31:0] y, logic [31:0] r, bit ill, bit it);
    vec_t v;
    v.nm = nm; v.op = op; v.f3 = f3; v.f7 = f7; v.x = x; v.y = y; v.r = r; v.ill = ill; v.it = it;
    return v;
  endfunction

  // Base-integer func3 table shared by I-type and non-M R-type.
  function automatic void base_op(input logic [2:0] f3, input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] r, output bit ill);
    r = 0; ill = 0;
    case (f3)
      3'b000: r = x + y;
      3'b100: r = x ^ y;
      3'b110: r = x | y;
      3'b111: r = x & y;
      3'b010: r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      3'b011: r = (x < y) ? 32'd1 : 32'd0;
      default: ill = 1;
    endcase
  endfunction

  function automatic void model(input logic [1:0] op, input logic [2:0] f3, input logic [1:0] f7,
                                input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] r, output bit ill, output bit it);
    logic [63:0] p;
    p = {32'b0, x} * {32'b0, y};
    r = 0; ill = 0; it = 0;
    case (op)
      2'b00: r = x + y;
      2'b01: r = x - y;
      2'b11: base_op(f3, x, y, r, ill);
      default: begin
        if (!f7[0]) begin
          base_op(f3, x, y, r, ill);
          if (f3 == 3'b000 && f7[1]) r = x - y;
        end else begin
          it = 1;
          case (f3)
            3'b000: r = p[31:0];
            3'b011: r = p[63:32];
            3'b101: r = (y == 0) ? 32'hFFFF_FFFF : x / y;
            3'b111: r = (y == 0) ? x : x % y;
            default: begin ill = 1; it = 0; end
          endcase
        end
      end
    endcase
  endfunction

  task automatic op_chk(input string nm, input logic [1:0] op, input logic [2:0] f3,
                        input logic [1:0] f7, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] er, input bit eill, input bit it, input bit b2b);
    int lat, nb;
    if (!b2b) @(negedge clk);
    ALUOp = op; func3 = f3; func7 = f7; a = x; b = y; start = 1;
    @(posedge clk); #1 start = 0;
    lat = 0; nb = 0;
    do begin
      @(negedge clk); lat++;
      if (busy) nb++;
      if (busy && done) ovl++;
    end while (!done && lat < 100);
    chk({nm, " latency"}, lat, it ? 33 : 1);
    chk({nm, " busy cycles"}, nb, it ? 32 : 0);
    chk({nm, " result"}, result, er);
    chk({nm, " zero"}, {31'b0, zero}, {31'b0, er == 0});
    chk({nm, " illegal"}, {31'b0, illegal}, {31'b0, eill});
  endtask

  initial begin
    logic [31:0] er, x, y;
    bit eill, eit;
    logic [1:0] op, f7;
    logic [2:0] f3;
    int lat, ndone;

    rst = 0; start = 0; ALUOp = 0; func3 = 0; func7 = 0; a = 0; b = 0;
    repeat (2) @(negedge clk);
    chk("reset result", result, 0);
    chk("reset zero", {31'b0, zero}, 1);
    chk("reset busy", {31'b0, busy}, 0);
    chk("reset done", {31'b0, done}, 0);
    chk("reset illegal", {31'b0, illegal}, 0);
    rst = 1;

    vt.push_back(mk("xori",      2'b11, 3'b100, 2'b00, 32'hF0F0_F0F0, 32'h0FF0_0000, 32'hFF00_F0F0, 0, 0));
    vt.push_back(mk("sub_zero",  2'b10, 3'b000, 2'b10, 5, 5, 0, 0, 0));
    vt.push_back(mk("slt",       2'b10, 3'b010, 2'b00, 32'hFFFF_FFFF, 1, 1, 0, 0));
    vt.push_back(mk("sltu",      2'b10, 3'b011, 2'b00, 32'hFFFF_FFFF, 1, 0, 0, 0));
    vt.push_back(mk("add_wrap",  2'b10, 3'b000, 2'b00, 32'hFFFF_FFFF, 2, 1, 0, 0));
    vt.push_back(mk("and",       2'b10, 3'b111, 2'b00, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 0, 0));
    vt.push_back(mk("or",        2'b10, 3'b110, 2'b00, 32'hF0F0_F0F0, 32'h0F00_0000, 32'hFFF0_F0F0, 0, 0));
    vt.push_back(mk("store_add", 2'b00, 3'b101, 2'b11, 10, 20, 30, 0, 0));
    vt.push_back(mk("br_sub",    2'b01, 3'b000, 2'b00, 3, 5, 32'hFFFF_FFFE, 0, 0));
    vt.push_back(mk("addi_f7",   2'b11, 3'b000, 2'b10, 7, 1, 8, 0, 0));
    vt.push_back(mk("slti",      2'b11, 3'b010, 2'b00, 32'h8000_0000, 0, 1, 0, 0));
    vt.push_back(mk("sltiu",     2'b11, 3'b011, 2'b00, 1, 2, 1, 0, 0));
    vt.push_back(mk("ill_i001",  2'b11, 3'b001, 2'b00, 5, 6, 0, 1, 0));
    vt.push_back(mk("ill_r101",  2'b10, 3'b101, 2'b00, 5, 6, 0, 1, 0));
    vt.push_back(mk("ill_m001",  2'b10, 3'b001, 2'b01, 5, 6, 0, 1, 0));
    vt.push_back(mk("mulhu",     2'b10, 3'b011, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, 1));
    vt.push_back(mk("mul",       2'b10, 3'b000, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0, 1));
    vt.push_back(mk("divu",      2'b10, 3'b101, 2'b01, 100, 7, 14, 0, 1));
    vt.push_back(mk("remu",      2'b10, 3'b111, 2'b01, 100, 7, 2, 0, 1));
    vt.push_back(mk("divu_b0",   2'b10, 3'b101, 2'b01, 100, 0, 32'hFFFF_FFFF, 0, 1));
    vt.push_back(mk("remu_b0",   2'b10, 3'b111, 2'b01, 100, 0, 100, 0, 1));
    foreach (vt[i])
      op_chk(vt[i].nm, vt[i].op, vt[i].f3, vt[i].f7, vt[i].x, vt[i].y, vt[i].r, vt[i].ill, vt[i].it, 0);

    // start pulsed mid-MUL with other operands must not disturb the product.
    @(negedge clk);
    ALUOp = 2'b10; func3 = 3'b000; func7 = 2'b01; a = 12345; b = 678; start = 1;
    @(posedge clk); #1 start = 0;
    repeat (5) @(negedge clk);
    a = 9; b = 9; start = 1;
    @(negedge clk); start = 0;
    lat = 6;
    while (!done && lat < 100) begin @(negedge clk); lat++; end
    chk("mid_mul latency", lat, 33);
    chk("mid_mul result", result, 32'(12345 * 678));

    // Back-to-back: start asserted in the DONE cycle.
    op_chk("b2b_first", 2'b10, 3'b101, 2'b01, 1000, 10, 100, 0, 1, 0);
    op_chk("b2b_second", 2'b10, 3'b111, 2'b01, 1000, 7, 6, 0, 1, 1);
    op_chk("b2b_alu", 2'b11, 3'b110, 2'b00, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 0, 0, 1);

    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      f3 = 3'($urandom_range(0, 7));
      f7 = 2'($urandom_range(0, 3));
      x  = $urandom;
      y  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) y = y >> $urandom_range(16, 31);
      model(op, f3, f7, x, y, er, eill, eit);
      op_chk($sformatf("rand%0d op%0d f3%0d f7%0d", i, op, f3, f7), op, f3, f7, x, y, er, eill, eit, 0);
    end

    // Reset mid-DIVU aborts with no done.
    op_chk("pre_reset_add", 2'b00, 3'b000, 2'b00, 1, 2, 3, 0, 0, 0);
    @(negedge clk);
    ALUOp = 2'b10; func3 = 3'b101; func7 = 2'b01; a = 1000; b = 3; start = 1;
    @(posedge clk); #1 start = 0;
    repeat (10) @(negedge clk);
    rst = 0; #1;
    chk("abort result", result, 0);
    chk("abort zero", {31'b0, zero}, 1);
    chk("abort busy", {31'b0, busy}, 0);
    chk("abort done", {31'b0, done}, 0);
    chk("abort illegal", {31'b0, illegal}, 0);
    @(negedge clk); rst = 1;
    ndone = 0;
    repeat (40) begin @(negedge clk); if (done || busy) ndone++; end
    chk("abort no done/busy", ndone, 0);

    chk("busy_done overlap", ovl, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/alu_mdu_unit.md
# alu_mdu_unit

Parametrised, registered ALU-plus-multiply/divide execution unit for the multi-cycle RISC-V datapath. It is the successor to the combinational ALU-control decode. It accepts the same ALUOp/func3/func7 control, decodes and executes base integer ops in one cycle, and runs RV32M-subset multiply/divide iteratively behind a start/busy/done handshake. The controller FSM stalls on `busy` and latches `result` on `done`.

## Interface
- `WIDTH`, 32: operand/result width (≥4).
- `clk`  in  1: clock, rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `start`  in  1: request; sampled only in IDLE or DONE.
- `ALUOp`  in  2: 00 store/addr (ADD), 01 branch (SUB), 10 R-type, 11 I-type.
- `func3`  in  3: instruction func3.
- `func7`  in  2: {instr[30], instr[25]}; bit1 = SUB select, bit0 = M-extension select.
- `a`, `b`  in  WIDTH: operands, sampled with accepted `start`.
- `result`  out  WIDTH: registered result.
- `zero`  out  1: `result == 0`, registered with `result`.
- `busy`  out  1: iterative op in progress.
- `done`  out  1: one-cycle pulse; `result` is valid.
- `illegal`  out  1: unsupported encoding; valid with `done`.

## Operation
- States: IDLE, MUL, DIV, DONE.
- Reset: state=IDLE, `result`=0, `zero`=1, `busy`=0, `done`=0, `illegal`=0, counter=0.
- Decode on accepted `start`:
  - ALUOp 00: ADD.
  - ALUOp 01: SUB.
  - ALUOp 11 (I-type), by func3: 000 ADD, 100 XOR, 110 OR, 111 AND, 010 SLT (signed), 011 SLTU. Other func3 is illegal.
  - ALUOp 10, func7[0]=0: func3 000 gives ADD when func7[1]=0 and SUB when func7[1]=1. Also 111 AND, 110 OR, 100 XOR, 010 SLT, 011 SLTU. Other func3 is illegal.
  - ALUOp 10, func7[0]=1: func3 000 MUL (low WIDTH of unsigned product), 011 MULHU (high WIDTH), 101 DIVU, 111 REMU. Other func3 is illegal.
- Single-cycle ops and illegal encodings go to DONE. Illegal encodings set `result`=0 and `illegal`=1.
- MUL/MULHU go to MUL: shift-add over a 2·WIDTH accumulator, one multiplier bit per cycle, WIDTH iterations.
- DIVU/REMU go to DIV: restoring divider, one quotient bit per cycle, WIDTH iterations.
- Divide by zero still runs the iterations. It must yield quotient = all-ones and remainder = `a` (RISC-V semantics), with `illegal`=0.
- DONE: `done`=1 for exactly one cycle.
  - `start` in DONE is accepted, giving back-to-back operation.
  - Otherwise return to IDLE.
- `result`/`zero` hold until the next op completes. `illegal` clears on the next accepted `start`.
- `start` during MUL/DIV is ignored; the operands are not re-sampled.
- SLT/SLTU result is zero-extended 1/0. All add/sub wraps modulo 2^WIDTH.

## Timing
- `start` accepted at edge N:
  - single-cycle op: `done`=1 and `result` valid in cycle N+1;
  - iterative op: `busy`=1 in cycles N+1 … N+WIDTH, then `done`=1 and `result` valid in cycle N+WIDTH+1.
- `busy` and `done` are never high together.
- Reset asserted mid-operation aborts immediately to reset values. No `done` is produced for the aborted op.
- Outputs are registered. No combinational path exists from inputs to outputs.

## Test plan
- Reset, then ALUOp=11, func3=100, a=0xF0F0_F0F0, b=0x0FF0_0000 → `done` at +1, `result`=0xFF00_F0F0, `zero`=0.
- ALUOp=10, func7=10, func3=000, a=5, b=5 → `result`=0, `zero`=1. Then ALUOp=10, func3=010, a=0xFFFF_FFFF, b=1 → `result`=1 (signed less-than).
- ALUOp=10, func7=01, func3=011, a=b=0xFFFF_FFFF → `busy` for 32 cycles, `done` at +33, `result`=0xFFFF_FFFE. Repeat with func3=000 → `result`=0x0000_0001.
- DIVU a=100, b=7 → `result`=14 at +33. REMU with the same operands → `result`=2. DIVU with b=0 → 0xFFFF_FFFF. REMU with b=0 → 100.
- `start` pulsed again mid-MUL (different operands) → ignored, original product returned. `start` asserted in the DONE cycle → accepted, next `done` at correct latency.
- ALUOp=11, func3=001 → `done` at +1, `illegal`=1, `result`=0. `rst` low at iteration 10 of a DIVU → all outputs at reset values, no `done`.
